pwm_duty_decoder: RTL and testbench

//  Receive side of the PWM link. Measures an incoming PWM waveform (e.g. the 10-step generator output)
//  and recovers high time, period and duty cycle in 10% steps (0..10). Sits at board inputs or in loopback.

---
 rtl/pwm_duty_decoder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder
// Receive side of the PWM link. Synchronises an asynchronous PWM input and measures
// each period and its high time. It then derives the duty cycle in 10% steps (0..10)
// with a small rounded restoring divider. On a quiet input it publishes a static
// 0%/100% result.

module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [3:0]       duty_tenths,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] period_cycles,
  output logic             result_valid,
  output logic             locked
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int DIV_W  = CNT_W + 4;

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(TIMEOUT);
  localparam logic [3:0]        DUTY_MAX  = 4'd10;

  typedef enum logic [1:0] {
    ST_WAIT_RISE = 2'd0,
    ST_HIGH      = 2'd1,
    ST_LOW       = 2'd2
  } state_t;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              w_rise;
  logic              w_fall;
  logic              w_edge;

  logic [CNT_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_hi;

  logic [IDLE_W-1:0] r_idle;
  logic              w_timeout;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_capture;

  logic              r_busy;
  logic [1:0]        r_step;
  logic [DIV_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_div;
  logic [3:0]        r_quo;
  logic [CNT_W-1:0]  r_cap_hi;
  logic [CNT_W-1:0]  r_cap_cyc;

  logic [DIV_W-1:0]  w_numer;
  logic [DIV_W-1:0]  w_div_shift;
  logic              w_sub_ok;
  logic [DIV_W-1:0]  w_rem_nxt;
  logic [3:0]        w_quo_nxt;
  logic [3:0]        w_duty_clip;
  logic              w_div_done;
  logic              w_publish_div;

  // --------------------------------------------------------------------------
  // Input synchroniser and edge detection
  // --------------------------------------------------------------------------

  // Three-stage shift of the raw input; s2 is the usable level and s3 its history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_edge = w_rise | w_fall;

  // --------------------------------------------------------------------------
  // Period and high-time counters
  // --------------------------------------------------------------------------

  // Count cycles since the last rise and high cycles since the last rise. The rise
  // cycle itself is the first cycle of the new period, so both counters reload to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cyc <= CNT_ZERO;
      r_hi  <= CNT_ZERO;
    end else if (w_rise) begin
      r_cyc <= CNT_ONE;
      r_hi  <= CNT_ONE;
    end else begin
      r_cyc <= sat_inc(r_cyc);
      if (r_s2) begin
        r_hi <= sat_inc(r_hi);
      end else begin
        r_hi <= r_hi;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Quiet-input timeout
  // --------------------------------------------------------------------------

  // A timeout fires once, in the cycle the idle count reaches TIMEOUT-1 with no edge.
  // Parking the counter at TIMEOUT stops it from firing again until an edge arrives.
  assign w_timeout = ~w_edge & (r_idle == IDLE_LAST);

  // Idle counter: reloads on any edge, stops at TIMEOUT after firing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle <= IDLE_ZERO;
    end else if (w_edge) begin
      r_idle <= IDLE_ONE;
    end else if (w_timeout) begin
      r_idle <= IDLE_FULL;
    end else if (r_idle != IDLE_FULL) begin
      r_idle <= r_idle + IDLE_ONE;
    end else begin
      r_idle <= r_idle;
    end
  end

  // --------------------------------------------------------------------------
  // Period-tracking FSM
  // --------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_RISE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state. A rise while LOW closes a complete period and starts a capture.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_WAIT_RISE;
    end else begin
      case (r_state)
        ST_WAIT_RISE: begin
          if (w_rise) begin
            w_state_nxt = ST_HIGH;
          end else begin
            w_state_nxt = ST_WAIT_RISE;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            w_state_nxt = ST_LOW;
          end else begin
            w_state_nxt = ST_HIGH;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HIGH;
          end else begin
            w_state_nxt = ST_LOW;
          end
        end
        default: begin
          w_state_nxt = ST_WAIT_RISE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Rounded duty divider: q = (10*hi + cyc/2) / cyc, 4 quotient bits
  // --------------------------------------------------------------------------

  // 10*hi is built as 8*hi + 2*hi. Adding cyc/2 makes the truncating division round.
  assign w_numer = ({4'd0, r_hi} << 3) + ({4'd0, r_hi} << 1)
                 + {5'd0, r_cyc[CNT_W-1:1]};

  assign w_div_shift = {4'd0, r_div} << r_step;
  assign w_sub_ok    = (r_rem >= w_div_shift);
  assign w_rem_nxt   = w_sub_ok ? (r_rem - w_div_shift) : r_rem;
  assign w_quo_nxt   = w_sub_ok ? (r_quo | (4'd1 << r_step)) : r_quo;
  assign w_duty_clip = (w_quo_nxt > DUTY_MAX) ? DUTY_MAX : w_quo_nxt;
  assign w_div_done  = r_busy & (r_step == 2'd0);

  // A capture in the completion cycle restarts the divider, so the older result is dropped.
  assign w_publish_div = w_div_done & ~w_capture;

  // Divider sequencing: load on capture, one restoring step per cycle, abort on timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_step    <= 2'd0;
      r_rem     <= {DIV_W{1'b0}};
      r_div     <= CNT_ZERO;
      r_quo     <= 4'd0;
      r_cap_hi  <= CNT_ZERO;
      r_cap_cyc <= CNT_ZERO;
    end else if (w_timeout) begin
      r_busy <= 1'b0;
      r_step <= 2'd0;
    end else if (w_capture) begin
      r_busy    <= 1'b1;
      r_step    <= 2'd3;
      r_rem     <= w_numer;
      r_div     <= r_cyc;
      r_quo     <= 4'd0;
      r_cap_hi  <= r_hi;
      r_cap_cyc <= r_cyc;
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_quo  <= w_quo_nxt;
      r_step <= r_step - 2'd1;
      if (r_step == 2'd0) begin
        r_busy <= 1'b0;
      end else begin
        r_busy <= 1'b1;
      end
    end else begin
      r_busy <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Result registers
  // --------------------------------------------------------------------------

  // Publish a timeout result (priority) or a completed division. Hold values otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_tenths   <= 4'd0;
      high_cycles   <= CNT_ZERO;
      period_cycles <= CNT_ZERO;
      result_valid  <= 1'b0;
      locked        <= 1'b0;
    end else if (w_timeout) begin
      duty_tenths   <= r_s2 ? DUTY_MAX : 4'd0;
      high_cycles   <= r_s2 ? CNT_MAX : CNT_ZERO;
      period_cycles <= CNT_ZERO;
      result_valid  <= 1'b1;
      locked        <= 1'b0;
    end else if (w_publish_div) begin
      duty_tenths   <= w_duty_clip;
      high_cycles   <= r_cap_hi;
      period_cycles <= r_cap_cyc;
      result_valid  <= 1'b1;
      locked        <= 1'b1;
    end else begin
      result_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Testbench for pwm_duty_decoder: randomized and directed PWM streams checked every cycle
// against an event-level reference model of period/high-time/duty measurement.

module tb_pwm_duty_decoder;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 40;

  logic             clk;
  logic             rst_n;
  logic             pwm_in;
  logic [3:0]       duty_tenths;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] period_cycles;
  logic             result_valid;
  logic             locked;

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm_in        (pwm_in),
    .duty_tenths   (duty_tenths),
    .high_cycles   (high_cycles),
    .period_cycles (period_cycles),
    .result_valid  (result_valid),
    .locked        (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // Reference model state. Edge n is the n-th posedge. An input change sampled at
  // edge k becomes an "event" at edge k+2. A rise event at edge e publishes at edge e+4.
  int   n = 0;
  logic h0, h1, h2, h3;
  int   last_e, rise_e, fall_e;
  bit   armed, fall_seen, tdone, pend_valid;
  int   pend_edge, pend_hi, pend_per, pend_duty;
  logic             e_valid, e_locked;
  logic [3:0]       e_duty;
  logic [CNT_W-1:0] e_hi, e_per;

  bit wave[$];

  function automatic int ref_duty(input int hi, input int per);
    int d;
    d = (10 * hi + per / 2) / per;
    if (d > 10) d = 10;
    return d;
  endfunction

  task automatic add_pwm(input int hi, input int per, input int reps);
    for (int r = 0; r < reps; r++)
      for (int c = 0; c < per; c++) wave.push_back(c < hi);
  endtask

  // Drive one sample, clock it, and advance the reference model to the post-edge state.
  task automatic tick(input logic v, input logic rst);
    bit ev_r, ev_f, fire, cap;
    pwm_in = v;
    rst_n  = rst;
    @(posedge clk);
    n++;
    if (!rst) begin
      {h0, h1, h2, h3} = 4'b0000;
      armed = 0; fall_seen = 0; tdone = 0; pend_valid = 0;
      last_e = n + 1;
      e_valid = 1'b0; e_locked = 1'b0; e_duty = 4'd0; e_hi = '0; e_per = '0;
    end else begin
      h3 = h2; h2 = h1; h1 = h0; h0 = v;
      ev_r = h2 && !h3;
      ev_f = !h2 && h3;
      e_valid = 1'b0;
      fire = !(ev_r || ev_f) && !tdone && (n == last_e + TIMEOUT - 1);
      cap  = ev_r && armed && fall_seen;
      if (fire) begin
        e_valid = 1'b1; e_locked = 1'b0;
        e_duty  = h2 ? 4'd10 : 4'd0;
        e_hi    = h2 ? {CNT_W{1'b1}} : '0;
        e_per   = '0;
        pend_valid = 0; armed = 0; fall_seen = 0; tdone = 1;
      end else begin
        if (pend_valid && pend_edge == n && !cap) begin
          e_valid = 1'b1; e_locked = 1'b1;
          e_duty = 4'(pend_duty); e_hi = CNT_W'(pend_hi); e_per = CNT_W'(pend_per);
          pend_valid = 0;
        end
        if (cap) begin
          pend_valid = 1;
          pend_edge  = n + 4;
          pend_per   = n - rise_e;
          pend_hi    = fall_e - rise_e;
          pend_duty  = ref_duty(pend_hi, pend_per);
        end
        if (ev_r) begin armed = 1; rise_e = n; fall_seen = 0; end
        if (ev_f && armed) begin fall_seen = 1; fall_e = n; end
      end
      if (ev_r || ev_f) begin last_e = n; tdone = 0; end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      cmp_cnt++;
      if ({result_valid, locked, duty_tenths, high_cycles, period_cycles} !== '0) begin
        fail_cnt++;
        $display("FAIL reset i=%0d got v=%b l=%b d=%0d h=%0d p=%0d want all zero",
                 i, result_valid, locked, duty_tenths, high_cycles, period_cycles);
      end
    end
  endtask

  task automatic test_basic();
    int pulses = 0;
    wave.delete();
    add_pwm(3, 10, 6);
    foreach (wave[i]) begin
      tick(wave[i], 1'b1);
      cmp_cnt++;
      if ({result_valid, locked, duty_tenths, high_cycles, period_cycles} !==
          {e_valid, e_locked, e_duty, e_hi, e_per}) begin
        fail_cnt++;
        $display("FAIL basic n=%0d got %h want %h", n,
                 {result_valid, locked, duty_tenths, high_cycles, period_cycles},
                 {e_valid, e_locked, e_duty, e_hi, e_per});
      end
      if (result_valid) pulses++;
    end
    cmp_cnt++;
    if (duty_tenths !== 4'd3 || high_cycles !== 16'd3 || period_cycles !== 16'd10 ||
        locked !== 1'b1 || pulses < 4) begin
      fail_cnt++;
      $display("FAIL basic_final got d=%0d h=%0d p=%0d l=%b pulses=%0d want 3/3/10/1 and >=4",
               duty_tenths, high_cycles, period_cycles, locked, pulses);
    end
  endtask

  task automatic test_rounding();
    int hs[4] = '{5, 1, 1, 19};
    int ps[4] = '{7, 3, 20, 20};
    int ds[4] = '{7, 3, 1, 10};
    for (int k = 0; k < 4; k++) begin
      int hits = 0;
      wave.delete();
      add_pwm(2, 10, 2);
      add_pwm(hs[k], ps[k], 1);
      add_pwm(2, 10, 2);
      foreach (wave[i]) begin
        tick(wave[i], 1'b1);
        cmp_cnt++;
        if ({result_valid, locked, duty_tenths, high_cycles, period_cycles} !==
            {e_valid, e_locked, e_duty, e_hi, e_per}) begin
          fail_cnt++;
          $display("FAIL rounding n=%0d got %h want %h", n,
                   {result_valid, locked, duty_tenths, high_cycles, period_cycles},
                   {e_valid, e_locked, e_duty, e_hi, e_per});
        end
        if (result_valid && period_cycles == 16'(ps[k])) begin
          hits++;
          cmp_cnt++;
          if (duty_tenths !== 4'(ds[k]) || high_cycles !== 16'(hs[k])) begin
            fail_cnt++;
            $display("FAIL rounding_%0d_%0d got d=%0d h=%0d want d=%0d h=%0d",
                     hs[k], ps[k], duty_tenths, high_cycles, ds[k], hs[k]);
          end
        end
      end
      cmp_cnt++;
      if (hits != 1) begin
        fail_cnt++;
        $display("FAIL rounding_seen_%0d_%0d got %0d results want 1", hs[k], ps[k], hits);
      end
    end
  endtask

  task automatic test_timeout();
    for (int lvl = 1; lvl >= 0; lvl--) begin
      int quiet_i, pulses = 0;
      wave.delete();
      add_pwm(3, 10, 4);
      if (lvl == 1) begin
        quiet_i = wave.size();
      end else begin
        repeat (3) wave.push_back(1'b1);
        quiet_i = wave.size();
      end
      repeat (TIMEOUT + 10) wave.push_back(lvl[0]);
      foreach (wave[i]) begin
        tick(wave[i], 1'b1);
        cmp_cnt++;
        if ({result_valid, locked, duty_tenths, high_cycles, period_cycles} !==
            {e_valid, e_locked, e_duty, e_hi, e_per}) begin
          fail_cnt++;
          $display("FAIL timeout n=%0d got %h want %h", n,
                   {result_valid, locked, duty_tenths, high_cycles, period_cycles},
                   {e_valid, e_locked, e_duty, e_hi, e_per});
        end
        if (i > quiet_i + 6 && result_valid) begin
          pulses++;
          cmp_cnt++;
          if (i != quiet_i + TIMEOUT + 1 || duty_tenths !== (lvl ? 4'd10 : 4'd0) ||
              period_cycles !== 16'd0 || locked !== 1'b0) begin
            fail_cnt++;
            $display("FAIL timeout_lvl%0d got at=%0d d=%0d p=%0d l=%b want at=%0d d=%0d p=0 l=0",
                     lvl, i - quiet_i, duty_tenths, period_cycles, locked,
                     TIMEOUT + 1, lvl ? 10 : 0);
          end
        end
      end
      cmp_cnt++;
      if (pulses != 1) begin
        fail_cnt++;
        $display("FAIL timeout_once_lvl%0d got %0d pulses want 1", lvl, pulses);
      end
    end
  endtask

  task automatic test_step_duty();
    bit seen5 = 0, seen6 = 0;
    wave.delete();
    add_pwm(5, 10, 4);
    add_pwm(6, 10, 4);
    foreach (wave[i]) begin
      tick(wave[i], 1'b1);
      cmp_cnt++;
      if ({result_valid, locked, duty_tenths, high_cycles, period_cycles} !==
          {e_valid, e_locked, e_duty, e_hi, e_per}) begin
        fail_cnt++;
        $display("FAIL step n=%0d got %h want %h", n,
                 {result_valid, locked, duty_tenths, high_cycles, period_cycles},
                 {e_valid, e_locked, e_duty, e_hi, e_per});
      end
      if (result_valid && locked) begin
        cmp_cnt++;
        if (!(duty_tenths == 4'd5 && !seen6) && duty_tenths !== 4'd6) begin
          fail_cnt++;
          $display("FAIL step_seq got d=%0d after6=%0d want 5 then 6", duty_tenths, seen6);
        end
        if (duty_tenths == 4'd5) seen5 = 1;
        if (duty_tenths == 4'd6) seen6 = 1;
      end
    end
    cmp_cnt++;
    if (!(seen5 && seen6)) begin
      fail_cnt++;
      $display("FAIL step_both got seen5=%0d seen6=%0d want 1 1", seen5, seen6);
    end
  endtask

  task automatic test_reset_mid();
    int rst_i;
    wave.delete();
    add_pwm(3, 10, 3);
    rst_i = wave.size() + 4;
    add_pwm(3, 10, 5);
    foreach (wave[i]) begin
      tick(wave[i], (i == rst_i) ? 1'b0 : 1'b1);
      cmp_cnt++;
      if ({result_valid, locked, duty_tenths, high_cycles, period_cycles} !==
          {e_valid, e_locked, e_duty, e_hi, e_per}) begin
        fail_cnt++;
        $display("FAIL reset_mid n=%0d got %h want %h", n,
                 {result_valid, locked, duty_tenths, high_cycles, period_cycles},
                 {e_valid, e_locked, e_duty, e_hi, e_per});
      end
      if (i >= rst_i && i < rst_i + 12) begin
        cmp_cnt++;
        if ({result_valid, locked, duty_tenths, high_cycles, period_cycles} !== '0) begin
          fail_cnt++;
          $display("FAIL reset_mid_quiet i=%0d got v=%b l=%b d=%0d want all zero",
                   i - rst_i, result_valid, locked, duty_tenths);
        end
      end
    end
  endtask

  task automatic test_short_period();
    int short_pulses = 0, resume_pulses = 0, short_len;
    wave.delete();
    add_pwm(2, 4, 10);
    short_len = wave.size();
    add_pwm(3, 10, 5);
    foreach (wave[i]) begin
      tick(wave[i], 1'b1);
      cmp_cnt++;
      if ({result_valid, locked, duty_tenths, high_cycles, period_cycles} !==
          {e_valid, e_locked, e_duty, e_hi, e_per}) begin
        fail_cnt++;
        $display("FAIL short n=%0d got %h want %h", n,
                 {result_valid, locked, duty_tenths, high_cycles, period_cycles},
                 {e_valid, e_locked, e_duty, e_hi, e_per});
      end
      if (result_valid && i >= 8 && i < short_len) short_pulses++;
      if (result_valid && i >= short_len) resume_pulses++;
    end
    cmp_cnt++;
    if (short_pulses != 0 || resume_pulses < 3) begin
      fail_cnt++;
      $display("FAIL short_count got short=%0d resume=%0d want 0 and >=3",
               short_pulses, resume_pulses);
    end
  endtask

  task automatic test_random();
    wave.delete();
    for (int k = 0; k < 25; k++) begin
      int p, h;
      p = int'($urandom_range(5, 30));
      h = int'($urandom_range(1, p - 1));
      add_pwm(h, p, 1 + int'($urandom_range(0, 1)));
    end
    foreach (wave[i]) begin
      tick(wave[i], 1'b1);
      cmp_cnt++;
      if ({result_valid, locked, duty_tenths, high_cycles, period_cycles} !==
          {e_valid, e_locked, e_duty, e_hi, e_per}) begin
        fail_cnt++;
        $display("FAIL random n=%0d got %h want %h", n,
                 {result_valid, locked, duty_tenths, high_cycles, period_cycles},
                 {e_valid, e_locked, e_duty, e_hi, e_per});
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_timeout();
    test_step_duty();
    test_reset_mid();
    test_short_period();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
